// File: rtl/fetch_npc_pkg.sv
// Shared definitions for the fetch stage: next-PC select encodings, nop word, reset PC.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fetch_npc_pkg;

    // D-stage next-PC select; encodings with bit 2 set are reserved and fall back to pc+4
    localparam logic [2:0] NPC_SEQ = 3'b000;
    localparam logic [2:0] NPC_BR  = 3'b001;
    localparam logic [2:0] NPC_J   = 3'b010;
    localparam logic [2:0] NPC_JR  = 3'b011;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Branch target relative to the delay slot: d_pc + 4 + sign_ext(imm16) * 4, modulo 2^32
    function automatic logic [31:0] br_target(input logic [31:0] br_pc, input logic [15:0] imm16);
        br_target = br_pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_npc_npc_calc.sv
// Next-PC selection from F-stage pc and IF/ID contents (seq / branch / j / jr).
// Latency: purely combinational.
// Backpressure: none; stalling is applied by the registers that consume npc.
// Ports: pc, d_pc, instr_idx (IF/ID instr[25:0]), npc_op, cmp_out, rs_fwd in; npc out.
module npc_calc
    import fetch_npc_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] d_pc,
    input  logic [25:0] instr_idx,
    input  logic [2:0]  npc_op,
    input  logic        cmp_out,
    input  logic [31:0] rs_fwd,
    output logic [31:0] npc
);

    logic [31:0] pc_plus4;
    logic [31:0] d_pc_plus4;

    assign pc_plus4   = pc + 32'd4;
    assign d_pc_plus4 = d_pc + 32'd4;

    always_comb begin
        npc = pc_plus4;
        case (npc_op)
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = cmp_out ? br_target(d_pc, instr_idx[15:0]) : pc_plus4;
            // Region bits come from the delay-slot address, not the jump's own PC
            NPC_J:   npc = {d_pc_plus4[31:28], instr_idx, 2'b00};
            // Register target is taken as-is; no alignment check
            NPC_JR:  npc = rs_fwd;
            default: npc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_npc.sv
// Fetch PC register, IF/ID register and next-PC select with MIPS delay-slot redirect.
// Latency: redirect decided in D at cycle n appears on pc at n+1; IF/ID is one register stage.
// Backpressure: stall=1 holds pc and IF/ID; this block never generates stalls.
// Ports: clk, reset (async active-low), stall, im_instr, cmp_out, npc_op, likely, rs_fwd in;
//        pc, d_instr, d_pc, d_pc8 out.
// Optional feature: BRANCH_LIKELY_EN nullifies the delay slot of a not-taken branch-likely.
module fetch_npc
    import fetch_npc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] im_instr,
    input  logic        cmp_out,
    input  logic [2:0]  npc_op,
    input  logic        likely,
    input  logic [31:0] rs_fwd,
    output logic [31:0] pc,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [31:0] d_pc8
);

    logic [31:0] npc;
    logic        nullify;

    npc_calc u_npc_calc (
        .pc        (pc),
        .d_pc      (d_pc),
        .instr_idx (d_instr[25:0]),
        .npc_op    (npc_op),
        .cmp_out   (cmp_out),
        .rs_fwd    (rs_fwd),
        .npc       (npc)
    );

`ifdef BRANCH_LIKELY_EN
    // Not-taken branch-likely: the delay-slot word is replaced by a nop on its way into IF/ID
    assign nullify = (npc_op == NPC_BR) && likely && !cmp_out;
`else
    logic unused_likely;
    assign unused_likely = likely;
    assign nullify       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            d_instr <= NOP;
            d_pc    <= RESET_PC;
        end else if (!stall) begin
            pc      <= npc;
            d_instr <= nullify ? NOP : im_instr;
            d_pc    <= pc;
        end
    end

    // Link value for jal/jalr: skip the branch and its delay slot
    assign d_pc8 = d_pc + 32'd8;

endmodule

// File: tb/tb_fetch_npc.sv
// Directed bench for fetch_npc: spec-level model checked every cycle plus hand-computed pc table.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [31:0] im_instr;
    logic        cmp_out;
    logic [2:0]  npc_op;
    logic        likely;
    logic [31:0] rs_fwd;
    logic [31:0] pc, d_instr, d_pc, d_pc8;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    fetch_npc dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .im_instr (im_instr),
        .cmp_out  (cmp_out),
        .npc_op   (npc_op),
        .likely   (likely),
        .rs_fwd   (rs_fwd),
        .pc       (pc),
        .d_instr  (d_instr),
        .d_pc     (d_pc),
        .d_pc8    (d_pc8)
    );

    // Instruction memory: a few control-flow words, every other address holds a distinct filler
    function automatic logic [31:0] im_word(input logic [31:0] a);
        case (a)
            32'h0000_3008: im_word = 32'h1000_FFFE;  // beq, offset -2
            32'h0000_3010: im_word = 32'h1400_0010;  // bne, offset +16
            32'h0000_3020: im_word = 32'h0C00_0C10;  // jal index 0xC10
            32'h0000_3030: im_word = 32'h1000_0003;  // beq, offset +3
            32'h0000_3040: im_word = 32'h03E0_0008;  // jr $ra
            default:       im_word = 32'h2400_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign im_instr = im_word(pc);

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc, m_di, m_dpc;

    function automatic logic [31:0] model_next(input logic [2:0] op, input logic c,
                                               input logic [31:0] rs, input logic [31:0] cur_pc,
                                               input logic [31:0] br_pc, input logic [31:0] br_instr);
        logic signed [31:0] off;
        logic [31:0]        slot;
        logic [15:0]        imm;
        imm  = br_instr[15:0];
        off  = $signed(imm);
        slot = br_pc + 32'd4;
        if (op == 3'd1 && c)  return slot + 32'(off * 4);
        else if (op == 3'd2)  return (slot & 32'hF000_0000) | ((br_instr & 32'h03FF_FFFF) * 4);
        else if (op == 3'd3)  return rs;
        else                  return cur_pc + 32'd4;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pc  = 32'h0000_3000;
            m_di  = 32'h0;
            m_dpc = 32'h0000_3000;
        end else if (!stall) begin
            logic [31:0] nxt;
            logic [31:0] fetched;
            nxt     = model_next(npc_op, cmp_out, rs_fwd, m_pc, m_dpc, m_di);
            fetched = im_word(m_pc);
`ifdef BRANCH_LIKELY_EN
            if (npc_op == 3'd1 && likely && !cmp_out) fetched = 32'h0;
`endif
            m_dpc = m_pc;
            m_di  = fetched;
            m_pc  = nxt;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run && reset) begin
            check("pc", pc, m_pc);
            check("d_instr", d_instr, m_di);
            check("d_pc", d_pc, m_dpc);
            check("d_pc8", d_pc8, m_dpc + 32'd8);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic        c;
        logic        lk;
        logic [31:0] rs;
        logic [31:0] exp_pc;
    } step_t;

    step_t steps[26];

    initial begin
        steps[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3004};
        steps[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3008};
        steps[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_300C};
        steps[3]  = '{1'b0, 3'd1, 1'b1, 1'b1, 32'h0,         32'h0000_3004}; // taken beq -2
        steps[4]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3008};
        steps[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_300C};
        steps[6]  = '{1'b0, 3'd1, 1'b0, 1'b0, 32'h0,         32'h0000_3010}; // not taken
        steps[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3014};
        steps[8]  = '{1'b0, 3'd1, 1'b0, 1'b1, 32'h0,         32'h0000_3018}; // bne, likely, not taken
        steps[9]  = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_301C};
        steps[10] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3020};
        steps[11] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3024};
        steps[12] = '{1'b0, 3'd2, 1'b0, 1'b0, 32'h0,         32'h0000_3040}; // jal
        steps[13] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3044};
        steps[14] = '{1'b0, 3'd3, 1'b0, 1'b0, 32'h0000_3028, 32'h0000_3028}; // jr
        steps[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_302C};
        steps[16] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3030};
        steps[17] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3034};
        steps[18] = '{1'b1, 3'd1, 1'b1, 1'b0, 32'h0,         32'h0000_3034}; // stalled
        steps[19] = '{1'b1, 3'd1, 1'b0, 1'b0, 32'h0,         32'h0000_3034}; // stalled
        steps[20] = '{1'b0, 3'd1, 1'b1, 1'b0, 32'h0,         32'h0000_3040}; // release, taken +3
        steps[21] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_3044};
        steps[22] = '{1'b0, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE}; // unaligned jr
        steps[23] = '{1'b0, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0000_0002}; // wraps
        steps[24] = '{1'b0, 3'd5, 1'b1, 1'b0, 32'h0,         32'h0000_0006}; // reserved op
        steps[25] = '{1'b0, 3'd6, 1'b1, 1'b0, 32'h5555_5555, 32'h0000_000A}; // reserved op

        reset = 1'b0; stall = 1'b0; cmp_out = 1'b0; npc_op = 3'd0; likely = 1'b0; rs_fwd = 32'h0;
        #12;
        check("rst_pc", pc, 32'h0000_3000);
        check("rst_d_instr", d_instr, 32'h0);
        check("rst_d_pc", d_pc, 32'h0000_3000);
        check("rst_d_pc8", d_pc8, 32'h0000_3008);

        @(negedge clk);
        reset = 1'b1;
        run   = 1'b1;
        for (int i = 0; i < 26; i++) begin
            stall = steps[i].st; npc_op = steps[i].op; cmp_out = steps[i].c;
            likely = steps[i].lk; rs_fwd = steps[i].rs;
            @(negedge clk);
            check($sformatf("step%0d_pc", i), pc, steps[i].exp_pc);
            if (i == 0) begin
                check("first_d_pc", d_pc, 32'h0000_3000);
                check("first_d_instr", d_instr, 32'h2400_3000);
            end
            if (i == 3) begin
                check("delay_slot_instr", d_instr, 32'h2400_300C);
                check("delay_slot_d_pc", d_pc, 32'h0000_300C);
            end
            if (i == 8) begin
`ifdef BRANCH_LIKELY_EN
                check("likely_nullified", d_instr, 32'h0);
`else
                check("likely_ignored", d_instr, 32'h2400_3014);
`endif
            end
            if (i == 11) check("jal_link", d_pc8, 32'h0000_3028);
            if (i == 19) begin
                check("stall_d_pc", d_pc, 32'h0000_3030);
                check("stall_d_instr", d_instr, 32'h1000_0003);
            end
            if (i == 23) check("wrap_d_pc8", d_pc8, 32'h0000_0006);
        end

        // Reset asserted mid-cycle while stalled with a branch pending in D
        stall = 1'b1; npc_op = 3'd1; cmp_out = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("midrst_pc", pc, 32'h0000_3000);
        check("midrst_d_instr", d_instr, 32'h0);
        check("midrst_d_pc", d_pc, 32'h0000_3000);
        @(negedge clk);
        check("held_rst_pc", pc, 32'h0000_3000);
        reset = 1'b1; stall = 1'b0; npc_op = 3'd0; cmp_out = 1'b0;
        @(negedge clk);
        check("post_rst_pc", pc, 32'h0000_3004);
        check("post_rst_d_instr", d_instr, 32'h2400_3000);
        @(negedge clk);
        run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
